// File: rtl/syscall_responder.sv
// Console-side syscall responder for requests issued from the MEM stage.
// Services print_int (v0=1), print_string (v0=4) and exit (v0=10). Strings are
// read word by word from data memory and streamed as ASCII bytes over a
// valid/ready channel. busy stays high while a request is in service.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   sig_syscall       request strobe, sampled on the rising edge while idle
//   v0, a0            syscall code and argument (integer or string address)
//   busy              high whenever a request is in service
//   mem_addr          word-aligned data-memory read address (combinational read)
//   mem_read_data     big-endian word for mem_addr, byte 0 in [31:24]
//   char_out          ASCII character, held until accepted
//   char_valid        char_out is valid
//   char_ready        sink accepts char_out this cycle
//   sig_done          one-cycle completion pulse, also on aborts
//   sig_exit          sticky exit flag, cleared only by reset
//   sig_error         one-cycle abort pulse, coincident with sig_done
module syscall_responder #(
    parameter int unsigned MAX_CHARS = 256,
    parameter logic [31:0] MEM_LO    = 32'h7FF0_0000,
    parameter logic [31:0] MEM_HI    = 32'h7FFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sig_syscall,
    input  logic [31:0] v0,
    input  logic [31:0] a0,
    output logic        busy,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_read_data,
    output logic [7:0]  char_out,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        sig_done,
    output logic        sig_exit,
    output logic        sig_error
);
    localparam int unsigned CNT_W = $clog2(MAX_CHARS + 1);

    typedef enum logic [2:0] {IDLE, LOAD, EMIT_STR, EMIT_HEX, DONE} stateT;

    stateT            state, stateNext;
    logic [31:0]      ptr, ptrNext;
    logic [31:0]      hexArg, hexArgNext;
    logic [31:0]      wordBuf, wordBufNext;
    logic [CNT_W-1:0] count, countNext;
    logic [2:0]       nibIdx, nibIdxNext;
    logic             exitNext, abortNext;
    logic [7:0]       curByte, curNext, charNext;
    logic             validNext;
    logic [31:0]      memAddrNext;

    // Byte lane of a big-endian word: lane 0 is the most significant byte.
    function automatic logic [7:0] laneByte(input logic [31:0] w, input logic [1:0] lane);
        case (lane)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

    // Lowercase ASCII hex digit.
    function automatic logic [7:0] hexAscii(input logic [3:0] n);
        return (n < 4'd10) ? (8'(n) + 8'd48) : (8'(n) + 8'd87);
    endfunction

    // State and registered outputs; outputs are decoded from the next state so
    // they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            hexArg     <= '0;
            wordBuf    <= '0;
            count      <= '0;
            nibIdx     <= '0;
            busy       <= 1'b0;
            mem_addr   <= '0;
            char_out   <= '0;
            char_valid <= 1'b0;
            sig_done   <= 1'b0;
            sig_exit   <= 1'b0;
            sig_error  <= 1'b0;
        end else begin
            state      <= stateNext;
            ptr        <= ptrNext;
            hexArg     <= hexArgNext;
            wordBuf    <= wordBufNext;
            count      <= countNext;
            nibIdx     <= nibIdxNext;
            busy       <= (stateNext != IDLE);
            mem_addr   <= memAddrNext;
            char_out   <= charNext;
            char_valid <= validNext;
            sig_done   <= (stateNext == DONE);
            sig_exit   <= exitNext;
            sig_error  <= (stateNext == DONE) && abortNext;
        end
    end

    // Next-state, datapath updates and next output values.
    always_comb begin
        stateNext   = state;
        ptrNext     = ptr;
        hexArgNext  = hexArg;
        wordBufNext = wordBuf;
        countNext   = count;
        nibIdxNext  = nibIdx;
        exitNext    = sig_exit;
        abortNext   = 1'b0;
        curByte     = laneByte(wordBuf, ptr[1:0]);

        case (state)
            IDLE: begin
                if (sig_syscall && !sig_exit) begin
                    hexArgNext = a0;
                    case (v0)
                        32'd1: begin
                            nibIdxNext = 3'd7;
                            stateNext  = EMIT_HEX;
                        end
                        32'd4: begin
                            ptrNext   = a0;
                            countNext = '0;
                            stateNext = LOAD;
                        end
                        32'd10: begin
                            exitNext  = 1'b1;
                            stateNext = DONE;
                        end
                        default: stateNext = DONE;
                    endcase
                end
            end
            LOAD: begin
                // A wrapped pointer also lands here and fails the range check.
                if ((ptr < MEM_LO) || (ptr > MEM_HI)) begin
                    abortNext = 1'b1;
                    stateNext = DONE;
                end else begin
                    wordBufNext = mem_read_data;
                    stateNext   = EMIT_STR;
                end
            end
            EMIT_STR: begin
                if (curByte == 8'h00) begin
                    stateNext = DONE;
                end else if (char_valid && char_ready) begin
                    ptrNext   = ptr + 32'd1;
                    countNext = count + CNT_W'(1);
                    if (countNext == CNT_W'(MAX_CHARS)) begin
                        abortNext = 1'b1;
                        stateNext = DONE;
                    end else if (ptrNext[1:0] == 2'b00) begin
                        stateNext = LOAD;
                    end
                end
            end
            EMIT_HEX: begin
                if (char_valid && char_ready) begin
                    if (nibIdx == 3'd0) stateNext = DONE;
                    else                nibIdxNext = nibIdx - 3'd1;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase

        // A NUL byte is never presented; EMIT_STR then just finishes.
        curNext   = laneByte(wordBufNext, ptrNext[1:0]);
        validNext = ((stateNext == EMIT_STR) && (curNext != 8'h00)) || (stateNext == EMIT_HEX);
        charNext  = 8'h00;
        if (stateNext == EMIT_HEX)
            charNext = hexAscii(hexArgNext[{nibIdxNext, 2'b00} +: 4]);
        else if (validNext)
            charNext = curNext;
        memAddrNext = (stateNext == LOAD) ? {ptrNext[31:2], 2'b00} : 32'h0;
    end
endmodule

// File: doc/syscall_responder.md
Name: syscall_responder

Overview:
- Console-side responder for syscall requests issued from the MEM stage (`sig_syscall`, `v0`, `a0`).
- Services print_int, print_string and exit. Walks data memory word by word for strings and streams ASCII bytes out over a valid/ready byte channel.
- Holds `busy` high while servicing so the hazard unit can stall the pipeline.

Parameters:
- MAX_CHARS, 256, maximum characters emitted for one print_string before it is aborted with an error.
- MEM_LO, 32'h7FF00000, lowest legal data-memory address.
- MEM_HI, 32'h7FFFFFFF, highest legal data-memory address.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sig_syscall  in  1  syscall request from the MEM stage; sampled on a rising edge.
- v0  in  32  syscall code.
- a0  in  32  argument: an integer value, or a string byte address.
- busy  out  1  high whenever the state is not IDLE.
- mem_addr  out  32  word-aligned read address to data memory; read is combinational.
- mem_read_data  in  32  word returned for mem_addr; big-endian, byte 0 is [31:24].
- char_out  out  8  ASCII character.
- char_valid  out  1  char_out holds a valid character.
- char_ready  in  1  sink accepts the character this cycle.
- sig_done  out  1  one-cycle pulse when a request completes, including error completions.
- sig_exit  out  1  sticky; set by exit (v0 = 10), cleared only by reset.
- sig_error  out  1  one-cycle pulse, coincident with sig_done, on abort.

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE.
  - All outputs 0, mem_addr = 0.
  - Internal ptr, count and buffer registers cleared.
  - Asserting reset mid-operation abandons the request immediately; no sig_done is produced.
- States: IDLE, LOAD, EMIT_STR, EMIT_HEX, DONE.
- IDLE:
  - On an edge with sig_syscall = 1 and sig_exit = 0, latch v0 and a0.
  - v0 = 1: go to EMIT_HEX with nibble index 7.
  - v0 = 4: ptr = a0, count = 0, go to LOAD.
  - v0 = 10: set sig_exit, go to DONE.
  - Any other v0: go to DONE (no-op).
  - While sig_exit = 1, sig_syscall is ignored.
  - sig_syscall in any non-IDLE state is ignored; no queueing.
- LOAD:
  - mem_addr = {ptr[31:2], 2'b00}.
  - If ptr < MEM_LO or ptr > MEM_HI: go to DONE with sig_error.
  - Otherwise capture mem_read_data into the word buffer and go to EMIT_STR. LOAD costs exactly one cycle.
- EMIT_STR:
  - cur = buffer byte at lane ptr[1:0]; lane 0 = [31:24], lane 3 = [7:0].
  - cur == 8'h00: go to DONE; no character is emitted and char_valid stays 0.
  - Otherwise char_valid = 1 and char_out = cur.
  - On char_valid & char_ready: ptr += 1 and count += 1, then:
    - if count + 1 == MAX_CHARS: go to DONE with sig_error;
    - else if the new ptr[1:0] == 0: go to LOAD;
    - else stay in EMIT_STR.
  - char_valid and char_out stay stable until accepted; char_valid never drops without a handshake.
- EMIT_HEX:
  - char_out = lowercase ASCII hex of a0 nibble [4i+3:4i], most significant nibble first (i = 7 down to 0).
  - Exactly 8 characters; no prefix, no newline.
  - On the handshake at i = 0: go to DONE.
- DONE:
  - sig_done = 1 for this one cycle; sig_error = 1 too if the request aborted.
  - Go to IDLE; busy drops on the following cycle.
- Ptr increment is 32-bit and wraps; the wrap is caught by the range check at the next LOAD.
- Throughput with char_ready tied high:
  - one character per cycle;
  - plus one LOAD cycle per word boundary crossed;
  - plus the accept cycle and the DONE cycle.

Test Plan:
1. Aligned string: memory[7FF00000] = 48_69_00_00 ("Hi\0"); v0 = 4, a0 = 7FF00000, char_ready = 1 -> chars 48, 69 on consecutive cycles. sig_done pulses 5 cycles after accept (LOAD, H, i, NUL-detect, DONE). busy is high throughout; sig_error = 0.
2. Unaligned string crossing a word: memory[7FF00000] = xx_xx_41_42, [7FF00004] = 43_00_xx_xx; a0 = 7FF00002 -> emits 41, 42, C (43). Exactly two LOAD cycles are observed on mem_addr: 7FF00000, then 7FF00004.
3. Backpressure: same as test 1 with char_ready held 0 for 3 cycles -> char_valid = 1 with char_out = 48 stable for all 3 cycles; no ptr advance; completion delayed by exactly 3 cycles.
4. print_int: v0 = 1, a0 = DEADBEEF -> emits "deadbeef" (64 65 61 64 62 65 65 66), then sig_done; no memory reads.
5. Error paths:
   - a0 = 00001000 -> sig_done and sig_error on the same cycle, with zero characters emitted.
   - MAX_CHARS = 4 with a 10-byte non-NUL string -> exactly 4 characters, then sig_error.
6. Exit and reset: v0 = 10 -> sig_exit = 1. A subsequent v0 = 1 request produces no busy and no chars. Asserting rst_n low mid-print_string clears sig_exit, busy and char_valid immediately (before the next clock edge), with no sig_done.
